// File: rtl/rmt_recovery_sequencer_if.sv
// Recovery sequencer bus: start/status, RRMT read port, active-list walk beats and RMT write ports.
// The sequencer uses the master view; the core/RMT side uses the slave view.
interface rmt_recovery_sequencer_if #(
    parameter int COPY_WIDTH  = 2,
    parameter int WRITE_WIDTH = 2,
    parameter int PREG_BITS   = 7,
    parameter int LREG_BITS   = 6
);
    localparam int CNT_BITS = $clog2(WRITE_WIDTH + 1);

    logic                                   start;
    logic                                   startMode;
    logic                                   busy;
    logic                                   done;
    logic [COPY_WIDTH-1:0][LREG_BITS-1:0]   rrmtReadIdx;
    logic [COPY_WIDTH-1:0][PREG_BITS-1:0]   rrmtReadData;
    logic                                   alValid;
    logic [CNT_BITS-1:0]                    alCount;
    logic                                   alLast;
    logic [WRITE_WIDTH-1:0]                 alWriteReg;
    logic [WRITE_WIDTH-1:0][LREG_BITS-1:0]  alLogDst;
    logic [WRITE_WIDTH-1:0][PREG_BITS-1:0]  alPrevPhy;
    logic [WRITE_WIDTH-1:0]                 rmtWe;
    logic [WRITE_WIDTH-1:0][LREG_BITS-1:0]  rmtWaddr;
    logic [WRITE_WIDTH-1:0][PREG_BITS-1:0]  rmtWdata;

    modport master (
        input  start, startMode, rrmtReadData,
        input  alValid, alCount, alLast, alWriteReg, alLogDst, alPrevPhy,
        output busy, done, rrmtReadIdx, rmtWe, rmtWaddr, rmtWdata
    );

    modport slave (
        output start, startMode, rrmtReadData,
        output alValid, alCount, alLast, alWriteReg, alLogDst, alPrevPhy,
        input  busy, done, rrmtReadIdx, rmtWe, rmtWaddr, rmtWdata
    );
endinterface

// File: rtl/rmt_recovery_sequencer.sv
// Restores the rename map table after a flush, either by bulk copy from the retirement RMT
// or by replaying previous mappings from an active-list walk.
//
//   state | meaning
//   IDLE  | no recovery; all RMT write ports quiet
//   COPY  | copying COPY_WIDTH RRMT entries per cycle into the RMT
//   WALK  | applying active-list beats (prevPhy -> logDst) as they arrive
module rmt_recovery_sequencer #(
    parameter int LREG_NUM    = 64,
    parameter int COPY_WIDTH  = 2,
    parameter int WRITE_WIDTH = 2,
    parameter int PREG_BITS   = 7,
    parameter int LREG_BITS   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    rmt_recovery_sequencer_if.master  bus
);
    localparam int REM_BITS = $clog2(LREG_NUM + 1);
    localparam logic [REM_BITS-1:0]  COPY_STEP = REM_BITS'(COPY_WIDTH);
    localparam logic [LREG_BITS-1:0] IDX_STEP  = LREG_BITS'(COPY_WIDTH);

    typedef enum logic [1:0] {IDLE, COPY, WALK} stateType;

    stateType             state, stateNext;
    logic [LREG_BITS-1:0] index, indexNext;
    logic [REM_BITS-1:0]  remaining, remainingNext;
    logic                 doneReg, doneNext;
    logic                 lastCopy;
    logic [REM_BITS-1:0]  copyStep;

    logic [COPY_WIDTH-1:0][LREG_BITS-1:0]  readIdx;
    logic [WRITE_WIDTH-1:0]                we;
    logic [WRITE_WIDTH-1:0][LREG_BITS-1:0] waddr;
    logic [WRITE_WIDTH-1:0][PREG_BITS-1:0] wdata;

    assign lastCopy = (remaining <= COPY_STEP);
    assign copyStep = lastCopy ? remaining : COPY_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            remaining <= '0;
            doneReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            index     <= indexNext;
            remaining <= remainingNext;
            doneReg   <= doneNext;
        end
    end

    // A start in any state restarts from scratch; an aborted recovery never reports done.
    always_comb begin
        stateNext     = state;
        indexNext     = index;
        remainingNext = remaining;
        doneNext      = 1'b0;
        if (bus.start) begin
            stateNext     = bus.startMode ? WALK : COPY;
            indexNext     = '0;
            remainingNext = bus.startMode ? '0 : REM_BITS'(LREG_NUM);
        end else begin
            case (state)
                COPY: begin
                    indexNext     = index + IDX_STEP;
                    remainingNext = remaining - copyStep;
                    if (lastCopy) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
                WALK: begin
                    if (bus.alValid && bus.alLast) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Start cycles are kept write-free so an abort never leaks a stale write.
    always_comb begin
        readIdx = '0;
        we      = '0;
        waddr   = '0;
        wdata   = '0;
        if (!bus.start) begin
            case (state)
                COPY: begin
                    for (int i = 0; i < COPY_WIDTH; i++) begin
                        waddr[i] = index + LREG_BITS'(i);
                        wdata[i] = bus.rrmtReadData[i];
                        if (i < int'(remaining)) begin
                            we[i]      = 1'b1;
                            readIdx[i] = index + LREG_BITS'(i);
                        end
                    end
                end
                WALK: begin
                    if (bus.alValid) begin
                        for (int i = 0; i < WRITE_WIDTH; i++) begin
                            we[i]    = (i < int'(bus.alCount)) && bus.alWriteReg[i];
                            waddr[i] = bus.alLogDst[i];
                            wdata[i] = bus.alPrevPhy[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = doneReg;
    assign bus.rrmtReadIdx = readIdx;
    assign bus.rmtWe       = we;
    assign bus.rmtWaddr    = waddr;
    assign bus.rmtWdata    = wdata;
endmodule

// File: doc/rmt_recovery_sequencer.md
RMT_RECOVERY_SEQUENCER -- requirements
Module: rmt_recovery_sequencer

Interface
REQ-001 Parameters SHALL be:
- LREG_NUM, default 64, number of logical registers restored.
- COPY_WIDTH, default 2, retirement-RMT (RRMT) read ports used per cycle.
- WRITE_WIDTH, default 2, RMT write ports; COPY_WIDTH <= WRITE_WIDTH is required.
- PREG_BITS, default 7, physical register number width.
- LREG_BITS, default 6, logical register number width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin a recovery.
- startMode, in, 1, 0 = copy from RRMT, 1 = walk the active list; sampled with start.
- busy, out, 1, recovery in progress; rename stalls while high.
- done, out, 1, one-cycle pulse when a recovery completes.
- rrmtReadIdx, out, COPY_WIDTH x LREG_BITS, RRMT read addresses.
- rrmtReadData, in, COPY_WIDTH x PREG_BITS, RRMT read data, combinational same cycle.
- alValid, in, 1, active-list walk beat present.
- alCount, in, clog2(WRITE_WIDTH+1), valid entries in the beat.
- alLast, in, 1, final beat of the walk.
- alWriteReg, in, WRITE_WIDTH x 1, entry writes a register.
- alLogDst, in, WRITE_WIDTH x LREG_BITS, entry logical destination.
- alPrevPhy, in, WRITE_WIDTH x PREG_BITS, entry previous physical destination.
- rmtWe, out, WRITE_WIDTH x 1, RMT write enables.
- rmtWaddr, out, WRITE_WIDTH x LREG_BITS, RMT write logical index.
- rmtWdata, out, WRITE_WIDTH x PREG_BITS, RMT write physical number.

Function
REQ-003 The FSM SHALL have states IDLE, COPY, WALK; busy SHALL be 1 exactly when the state is COPY or WALK.
REQ-004 In IDLE, start with startMode=0 SHALL enter COPY with index=0 and remaining=LREG_NUM; start with startMode=1 SHALL enter WALK.
REQ-005 The remaining counter SHALL be clog2(LREG_NUM+1) bits wide and the index counter LREG_BITS wide.
REQ-006 In COPY, each cycle, port i < COPY_WIDTH SHALL drive:
- rrmtReadIdx[i] = index+i;
- rmtWaddr[i] = index+i;
- rmtWdata[i] = rrmtReadData[i];
- rmtWe[i] = (i < remaining).
REQ-007 In COPY, rrmtReadIdx[i] SHALL be 0 whenever i >= remaining.
REQ-008 In COPY, ports COPY_WIDTH..WRITE_WIDTH-1 SHALL have rmtWe=0 and zero address and data.
REQ-009 Each COPY cycle SHALL advance index by COPY_WIDTH and decrement remaining by min(COPY_WIDTH, remaining).
REQ-010 When remaining <= COPY_WIDTH, the next state SHALL be IDLE.
REQ-011 A full copy SHALL take ceil(LREG_NUM/COPY_WIDTH) cycles; LREG_NUM not divisible by COPY_WIDTH gives a partial last cycle.
REQ-012 In WALK with alValid=1, port i SHALL drive rmtWe[i] = (i < alCount) && alWriteReg[i], rmtWaddr[i] = alLogDst[i], rmtWdata[i] = alPrevPhy[i].
REQ-013 In WALK with alValid=0, all rmtWe SHALL be 0 and the state SHALL hold.
REQ-014 In WALK, alValid && alLast SHALL write that beat and return to IDLE.
REQ-015 In a WALK beat, port i+1 SHALL be older than port i, so port i+1 is written after port i.
REQ-016 The block SHALL NOT deduplicate writes to the same logical register; the RMT gives the higher-numbered port priority.
REQ-017 done SHALL be a registered pulse, high for exactly one cycle, in the cycle after the last write cycle of a COPY or WALK.
REQ-018 start while busy SHALL abort the current recovery and restart in the newly sampled mode.
REQ-019 On an aborted recovery, done SHALL NOT pulse for the aborted recovery, and no RMT write SHALL occur in the start cycle.
REQ-020 In IDLE, all rmtWe SHALL be 0, and all addresses and data SHALL be 0.
REQ-021 In IDLE, alValid SHALL be ignored.

Reset
REQ-022 While rst=1, asynchronously: state=IDLE, index=0, remaining=0, busy=0, done=0, all rmtWe=0, and all address and data outputs 0.
REQ-023 rst asserted mid-recovery SHALL abandon the recovery with no done pulse.
REQ-024 After rst deasserts, the first start SHALL be accepted on the first clk edge.

Verification
REQ-025 Full copy, LREG_NUM=64, COPY_WIDTH=2, start mode 0 -> busy for 32 cycles; writes idx 0..63 in order; each rmtWdata equals rrmtReadData; done pulses once in cycle 33.
REQ-026 Partial copy, LREG_NUM=5, COPY_WIDTH=2 -> 3 copy cycles; last cycle has rmtWe={1,0}, rmtWaddr[0]=4, rrmtReadIdx[1]=0.
REQ-027 Walk -> beats (count=2, writeReg={1,0}) then (count=1, last=1), with one idle gap between -> writes only port 0 in each beat; the gap writes nothing; done in the cycle after the last beat.
REQ-028 Abort -> start mode 1 at copy cycle 5 -> no write in the start cycle; copy stops; walk proceeds; exactly one done pulse.
REQ-029 Reset at copy cycle 10 -> busy=0 and rmtWe=0 immediately (asynchronous); no done pulse; a new start afterwards copies from idx 0.
REQ-030 Same-register beat -> alLogDst={3,3}, count=2 -> both ports enabled, RMT holds port-1 data.
